// File: rtl/rc4_pkg.sv
// ---- rc4_pkg : shared RC4 key-schedule constants, state encoding and k-step helper ----
// ---- Rev 1.0 ----
`default_nettype none

package rc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_ADDR_W  = 8;
  localparam int S_DEPTH   = 256;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ARM     = 4'd1,
    INIT    = 4'd2,
    RD_SI   = 4'd3,
    WAIT_SI = 4'd4,
    RD_SJ   = 4'd5,
    WAIT_SJ = 4'd6,
    WR_SI   = 4'd7,
    WR_SJ   = 4'd8,
    DONE    = 4'd9
  } ksa_state_t;

  function automatic logic [1:0] next_k(input logic [1:0] k);
    return (k == 2'(KEY_BYTES - 1)) ? 2'd0 : k + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_fsm_if.sv
// ---- ksa_fsm_if : key-in / S-RAM / status bundle; master = KSA engine, slave = key source + RAM ----
// ---- Rev 1.0 ----
`default_nettype none

interface ksa_fsm_if;
  import rc4_pkg::*;

  logic [8*KEY_BYTES-1:0] secret_key;
  logic                   key_available;
  logic                   key_changed;
  logic [S_ADDR_W-1:0]    mem_addr;
  logic [7:0]             mem_data;
  logic                   mem_wren;
  logic [7:0]             mem_q;
  logic                   busy;
  logic                   done;

  modport master (
    input  secret_key, key_available, key_changed, mem_q,
    output mem_addr, mem_data, mem_wren, busy, done
  );

  modport slave (
    output secret_key, key_available, key_changed, mem_q,
    input  mem_addr, mem_data, mem_wren, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/key_byte_sel.sv
// ---- key_byte_sel : picks key byte k (0 = MSB byte) from the 24-bit key ----
// ---- Rev 1.0 ----
`default_nettype none

module key_byte_sel
  import rc4_pkg::*;
(
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic [1:0]             k_i,
  output logic [7:0]             byte_o
);

  always_comb begin
    byte_o = 8'd0;
    case (k_i)
      2'd0:    byte_o = key_i[23:16];
      2'd1:    byte_o = key_i[15:8];
      2'd2:    byte_o = key_i[7:0];
      default: byte_o = 8'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ksa_fsm.sv
// ---- ksa_fsm : RC4 key-scheduling FSM driving an external 256-byte S-RAM with 1-cycle read latency ----
// ---- Rev 1.0 ; macro KSA_INIT_EN adds the S[i]=i INIT pass (otherwise S must be preloaded) ----
`default_nettype none

module ksa_fsm
  import rc4_pkg::*;
(
  input  logic      CLOCK_50,
  input  logic      reset_n,
  ksa_fsm_if.master bus
);

  localparam logic [S_ADDR_W-1:0] c_LAST_IDX = S_ADDR_W'(S_DEPTH - 1);

  ksa_state_t             state_q;
  logic [S_ADDR_W-1:0]    i_q, j_q;
  logic [1:0]             k_q;
  logic [7:0]             si_q, sj_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [S_ADDR_W-1:0]    addr_q;
  logic [7:0]             data_q;
  logic                   wren_q, busy_q, done_q;
  logic [7:0]             key_byte;
  logic [S_ADDR_W-1:0]    j_new;

  key_byte_sel u_key_byte_sel (
    .key_i  (key_q),
    .k_i    (k_q),
    .byte_o (key_byte)
  );

  // j advances on entry to RD_SJ, using S[i] straight off the RAM, so j_new is on the bus throughout RD_SJ
  assign j_new = j_q + bus.mem_q + key_byte;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.key_changed) begin
      state_q <= ARM;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
        end
        ARM: begin
          if (bus.key_available) begin
            key_q  <= bus.secret_key;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            addr_q <= '0;
            data_q <= '0;
`ifdef KSA_INIT_EN
            state_q <= INIT;
            wren_q  <= 1'b1;
`else
            state_q <= RD_SI;
            wren_q  <= 1'b0;
`endif
          end
        end
`ifdef KSA_INIT_EN
        INIT: begin
          if (i_q == c_LAST_IDX) begin
            state_q <= RD_SI;
            i_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
          end else begin
            i_q    <= i_q + 8'd1;
            addr_q <= i_q + 8'd1;
            data_q <= i_q + 8'd1;
          end
        end
`endif
        RD_SI: state_q <= WAIT_SI;
        WAIT_SI: begin
          si_q    <= bus.mem_q;
          j_q     <= j_new;
          addr_q  <= j_new;
          state_q <= RD_SJ;
        end
        RD_SJ: state_q <= WAIT_SJ;
        WAIT_SJ: begin
          sj_q    <= bus.mem_q;
          addr_q  <= i_q;
          wren_q  <= 1'b1;
          state_q <= WR_SI;
        end
        WR_SI: begin
          addr_q  <= j_q;
          data_q  <= si_q;
          state_q <= WR_SJ;
        end
        WR_SJ: begin
          wren_q <= 1'b0;
          if (i_q == c_LAST_IDX) begin
            state_q <= DONE;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            i_q     <= i_q + 8'd1;
            k_q     <= next_k(k_q);
            addr_q  <= i_q + 8'd1;
            state_q <= RD_SI;
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          data_q  <= '0;
          wren_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // sj is only known at the WAIT_SJ edge, so the WR_SI write data comes from its own register
  assign bus.mem_data = (state_q == WR_SI) ? sj_q : data_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wren = wren_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ksa_fsm.sv
// ---- tb_ksa_fsm : self-checking bench for ksa_fsm with a behavioural S-RAM and a software KSA model ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_ksa_fsm;

`ifdef KSA_INIT_EN
  localparam int LAT = 1793;
  localparam int WRS = 768;
`else
  localparam int LAT = 1537;
  localparam int WRS = 512;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ksa_fsm_if bus ();

  ksa_fsm dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  logic [7:0] ram   [256];
  logic [7:0] model [256];
  int  cyc = 0;
  int  wr_cnt = 0;
  logic preload_req = 1'b0;
  logic clr_req = 1'b0;
`ifdef KSA_INIT_EN
  logic [7:0] log_a [256];
  logic [7:0] log_d [256];
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload_req) begin
      for (int a = 0; a < 256; a++) begin
`ifdef KSA_INIT_EN
        ram[a] <= 8'(a * 7 + 3);
`else
        ram[a] <= 8'(a);
`endif
      end
    end else if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_data;
    end
    if (clr_req) begin
      wr_cnt <= 0;
    end else if (bus.mem_wren) begin
      wr_cnt <= wr_cnt + 1;
`ifdef KSA_INIT_EN
      if (wr_cnt < 256) begin
        log_a[wr_cnt] <= bus.mem_addr;
        log_d[wr_cnt] <= bus.mem_data;
      end
`endif
    end
    bus.mem_q <= ram[bus.mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic compute_model(input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int a = 0; a < 256; a++) model[a] = 8'(a);
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = j + model[i] + kb;
      t = model[i];
      model[i] = model[j];
      model[j] = t;
    end
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++)
      if (ram[a] !== model[a]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic preload();
    @(negedge clk);
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // pulse key_changed; t0 is the cycle count right after the sampling edge
  task automatic start_run(input logic [23:0] key, input logic avail, output int t0);
    @(negedge clk);
    bus.secret_key    = key;
    bus.key_available = avail;
    bus.key_changed   = 1'b1;
    clr_req           = 1'b1;
    @(negedge clk);
    bus.key_changed = 1'b0;
    clr_req         = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    int budget = 4000;
    while (!bus.done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    lat = bus.done ? (cyc - t0) : -1;
  endtask

  typedef struct {
    logic [23:0] key;
    int          lat;
    int          wrs;
  } vec_t;

  vec_t vecs [5];
  int   t0, lat, flag;

  initial begin
    vecs[0] = '{24'h000000, LAT, WRS};
    vecs[1] = '{24'h00035F, LAT, WRS};
    vecs[2] = '{24'h0003FF, LAT, WRS};
    vecs[3] = '{24'h000249, LAT, WRS};
    vecs[4] = '{24'hA5C33C, LAT, WRS};

    rst_n             = 1'b0;
    bus.secret_key    = '0;
    bus.key_available = 1'b0;
    bus.key_changed   = 1'b0;

    #3;
    chk("reset_outputs_preclock",
        int'({bus.mem_addr, bus.mem_data, bus.mem_wren, bus.busy, bus.done}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", int'({bus.mem_wren, bus.busy, bus.done}), 0);

    for (int v = 0; v < 5; v++) begin
      preload();
      compute_model(vecs[v].key);
      start_run(vecs[v].key, 1'b1, t0);
      wait_done(t0, lat);
      chk($sformatf("latency_key%06h", vecs[v].key), lat, vecs[v].lat);
      chk($sformatf("wren_count_key%06h", vecs[v].key), wr_cnt, vecs[v].wrs);
      check_ram($sformatf("ram_bad_bytes_key%06h", vecs[v].key));
      chk("done_busy_wren", int'({bus.busy, bus.done, bus.mem_wren}), 2);
      chk("done_addr", int'(bus.mem_addr), 0);
`ifdef KSA_INIT_EN
      flag = 0;
      for (int n = 0; n < 256; n++)
        if (log_a[n] != 8'(n) || log_d[n] != 8'(n)) flag++;
      chk("init_write_order_bad", flag, 0);
`endif
    end

    // abort mid-shuffle at edge 600 and restart with a new key
    preload();
    compute_model(24'h0003FF);
    start_run(24'h000249, 1'b1, t0);
    while (cyc - t0 < 599) @(negedge clk);
    bus.secret_key  = 24'h0003FF;
    bus.key_changed = 1'b1;
    clr_req         = 1'b1;
`ifndef KSA_INIT_EN
    bus.key_available = 1'b0;
`endif
    @(negedge clk);
    bus.key_changed = 1'b0;
    clr_req         = 1'b0;
    t0 = cyc;
    chk("abort_arm_busy_wren", int'({bus.busy, bus.mem_wren}), 2);
`ifdef KSA_INIT_EN
    @(negedge clk);
    chk("abort_reinit_addr_wren", int'({bus.mem_addr, bus.mem_wren}), 1);
    wait_done(t0, lat);
`else
    preload();
    start_run(24'h0003FF, 1'b1, t0);
    wait_done(t0, lat);
`endif
    chk("abort_latency", lat, LAT);
    chk("abort_wren_count", wr_cnt, WRS);
    check_ram("abort_ram_bad_bytes");

    // key_available held low keeps the block parked in ARM
    start_run(24'h00035F, 1'b0, t0);
    flag = 0;
    for (int n = 0; n < 40; n++) begin
      if (!(bus.busy && !bus.mem_wren && !bus.done)) flag++;
      @(negedge clk);
    end
    chk("arm_hold_bad_cycles", flag, 0);

    // asynchronous reset in the middle of the shuffle
    preload();
    start_run(24'h00035F, 1'b1, t0);
    while (cyc - t0 < 900) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({bus.mem_addr, bus.mem_data, bus.mem_wren, bus.busy, bus.done}), 0);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rst_n   = 1'b1;
    repeat (6) @(negedge clk);
    chk("writes_after_release", wr_cnt, 0);
    chk("idle_after_mid_reset", int'({bus.busy, bus.done}), 0);

    preload();
    compute_model(24'h00035F);
    start_run(24'h00035F, 1'b1, t0);
    wait_done(t0, lat);
    chk("post_reset_latency", lat, LAT);
    check_ram("post_reset_ram_bad_bytes");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
